// File: rtl/ov5640_pix_pack_pkg.sv
// Shared widths and FIFO entry layout for the OV5640 pixel packer.
// Holds types only, so it has no latency and no backpressure of its own.
package ov5640_pix_pack_pkg;

  localparam int H_PIXEL_DEF = 640;
  localparam int PIX_W       = 16;
  localparam int WORD_W      = 32;
  localparam int COL_W       = 11;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [WORD_W-1:0] dat;
  } pix_ent_t;

  localparam int ENT_W = $bits(pix_ent_t);

endpackage

// File: rtl/pix_fifo_sync.sv
// Single-clock first-word-fall-through FIFO; a write becomes visible at the head one cycle later.
// Writes while full are refused (the caller sees full); reads while empty are ignored.
module pix_fifo_sync #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             ov5640_pclk,
  input  logic             sys_rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign wr_en  = wr_vld & ~full;
  assign rd_en  = rd_rdy & ~empty;
  // Head is forced to zero when empty so nothing stale leaks out after reset.
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge ov5640_pclk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ov5640_pix_pack.sv
// Packs RGB565 pixel pairs into 32-bit words tagged sof/eol; m_valid rises one cycle after the second pixel.
// Output is valid/ready through a FWFT FIFO; words arriving while it is full are dropped and flagged.
module ov5640_pix_pack
  import ov5640_pix_pack_pkg::*;
#(
  parameter  int H_PIXEL    = H_PIXEL_DEF,
  parameter  int FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              ov5640_pclk,
  input  logic              sys_rst_n,
  input  logic              ov5640_vsync,
  input  logic              pix_en,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              ovf_err,
  output logic              sync_err
);

  logic             vsync_dly;
  logic             armed;
  logic             phase;
  logic [COL_W-1:0] col;
  logic             sof_pend;
  logic [PIX_W-1:0] hi_pix;

  logic             frame_start;
  logic             pix_acc;
  logic             cur_phase;
  logic [COL_W-1:0] cur_col;
  logic             last_col;
  logic             word_vld;
  pix_ent_t         word_ent;
  pix_ent_t         head_ent;
  logic             fifo_full;
  logic             fifo_empty;

  assign frame_start = ov5640_vsync & ~vsync_dly;
  // A pixel coinciding with frame start belongs to the new frame, so it sees cleared phase/column.
  assign pix_acc     = pix_en & (armed | frame_start);
  assign cur_phase   = phase & ~frame_start;
  assign cur_col     = frame_start ? '0 : col;
  assign last_col    = (cur_col == COL_W'(H_PIXEL - 1));
  assign word_vld    = pix_acc & cur_phase;

  assign word_ent.sof = sof_pend;
  assign word_ent.eol = last_col;
  assign word_ent.dat = {hi_pix, pix_data};

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_dly <= 1'b0;
      armed     <= 1'b0;
      phase     <= 1'b0;
      col       <= '0;
      sof_pend  <= 1'b0;
      hi_pix    <= '0;
      ovf_err   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      vsync_dly <= ov5640_vsync;
      if (frame_start) begin
        armed    <= 1'b1;
        sof_pend <= 1'b1;
        phase    <= 1'b0;
        col      <= '0;
        if (phase) sync_err <= 1'b1;
      end
      if (pix_acc) begin
        phase <= ~cur_phase;
        col   <= last_col ? '0 : cur_col + 1'b1;
        if (!cur_phase) hi_pix <= pix_data;
      end
      if (word_vld) sof_pend <= 1'b0;
      if (word_vld && fifo_full) ovf_err <= 1'b1;
    end
  end

  pix_fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ov5640_pclk (ov5640_pclk),
    .sys_rst_n   (sys_rst_n),
    .wr_vld      (word_vld),
    .wr_dat      (word_ent),
    .rd_rdy      (m_ready),
    .rd_dat      (head_ent),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .level       (fifo_level)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = head_ent.dat;
  assign m_sof   = head_ent.sof;
  assign m_eol   = head_ent.eol;

endmodule

// File: doc/ov5640_pix_pack.md
OV5640_PIX_PACK -- requirements
Module: ov5640_pix_pack

Interface
REQ-001 Parameter H_PIXEL, default 640, SHALL set pixels per line; it SHALL be even and no larger than 2047.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set output FIFO depth in 32-bit words; it SHALL be a power of two.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous, active-low reset, named ov5640_pclk and sys_rst_n.
REQ-004 ov5640_pclk  input  1  camera pixel clock; all logic rising-edge.
REQ-005 sys_rst_n  input  1  asynchronous active-low reset.
REQ-006 ov5640_vsync  input  1  camera frame sync; rising edge marks frame start.
REQ-007 pix_en  input  1  16-bit pixel valid strobe from the capture stage.
REQ-008 pix_data  input  16  RGB565 pixel, sampled when pix_en=1.
REQ-009 m_valid  output  1  output word available.
REQ-010 m_ready  input  1  consumer accepts word when m_valid & m_ready.
REQ-011 m_data  output  32  packed pixel pair.
REQ-012 m_sof  output  1  word holds the first pixel of a frame.
REQ-013 m_eol  output  1  word holds the last pixel of a line.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently stored.
REQ-015 ovf_err  output  1  sticky: word dropped because FIFO full.
REQ-016 sync_err  output  1  sticky: odd pixel count at frame start.

Function
REQ-017 vsync_dly SHALL register ov5640_vsync; frame_start = ov5640_vsync & ~vsync_dly.
REQ-018 Packer SHALL hold phase bit; pixel at phase 0 goes to [31:16], pixel at phase 1 to [15:0], completing a word.
REQ-019 Column counter SHALL count accepted pixels 0..H_PIXEL-1 and wrap to 0 after H_PIXEL-1.
REQ-020 Completed word SHALL carry eol=1 iff its second pixel has column H_PIXEL-1.
REQ-021 sof_pend SHALL set on frame_start; first completed word after it SHALL carry sof=1 and clear sof_pend.
REQ-022 On frame_start, phase and column SHALL clear; if phase was 1, the half word SHALL be discarded and sync_err set.
REQ-023 frame_start and pix_en in the same cycle: frame_start clears state first; that pixel SHALL be column 0, phase 0, of the new frame.
REQ-024 Completed word {sof,eol,data} (34 bits) SHALL be written to the FIFO in the cycle after the phase-1 pixel.
REQ-025 FIFO SHALL be first-word-fall-through: m_valid = ~empty; m_data/m_sof/m_eol reflect head entry combinationally from storage.
REQ-026 Latency: m_valid SHALL assert one cycle after the phase-1 pix_en cycle when FIFO was empty.
REQ-027 Write when full SHALL be dropped, ovf_err set, even if a read occurs in the same cycle.
REQ-028 Simultaneous read and write when not full and not empty SHALL leave fifo_level unchanged.
REQ-029 Read when empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-030 m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-031 ovf_err and sync_err SHALL clear only on reset.

Reset
REQ-032 On sys_rst_n=0: m_valid=0, m_data=0, m_sof=0, m_eol=0, fifo_level=0, ovf_err=0, sync_err=0, phase=0, column=0, sof_pend=0, vsync_dly=0.
REQ-033 Reset mid-frame SHALL discard FIFO contents and the partial word; packing resumes only after the next frame_start.
REQ-034 Before the first frame_start after reset, pix_en SHALL be ignored.

Structure
REQ-035 Shared package SHALL hold H_PIXEL default, pixel width 16, word width 32, and FIFO entry layout {sof,eol,data}.
REQ-036 FIFO SHALL be a separate sub-module pix_fifo_sync (parameterised width/depth, full/empty/level).

Verification
REQ-037 One frame, 640 pixels 0x0001..0x0280, m_ready=1 -> 320 words, first 0x00010002 with sof=1, last 0x027F0280 with eol=1.
REQ-038 m_ready=0, 40 pixels -> fifo_level=16, ovf_err=1, first 16 words intact after m_ready=1.
REQ-039 Three pixels then frame_start -> sync_err=1, third pixel discarded, next word sof=1.
REQ-040 frame_start coincident with pix_en (0xAAAA) -> next word [31:16]=0xAAAA, sof=1.
REQ-041 Reset asserted with 5 words queued -> m_valid=0, fifo_level=0 immediately; pixels ignored until next vsync rise.
REQ-042 m_ready toggling every cycle at full input rate -> no loss, order preserved, ovf_err=0.
